// File: rtl/ddr3_axi_pkg.sv
//------------------------------------------------------------------------------
// ddr3_axi_pkg: shared AXI constants and FSM encodings for the BRAM responder. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ddr3_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr3_axi_bram_mem.sv
//------------------------------------------------------------------------------
// ddr3_axi_bram_mem: simple dual-port RAM, byte-enabled write, registered read-first read. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ddr3_axi_bram_mem #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   waddr,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  input  logic [DEPTH_LOG2-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Read and write share one block so a same-index collision returns the old word.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
    if (we) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (wstrb[i]) begin
          mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ddr3_axi_bram_responder.sv
//------------------------------------------------------------------------------
// ddr3_axi_bram_responder: AXI4 slave that stands in for DDR3 using on-chip BRAM. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ddr3_axi_bram_responder
  import ddr3_axi_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH   = 12,
  parameter int C_AXI_ADDR_WIDTH = 33,
  parameter int C_AXI_DATA_WIDTH = 256,
  parameter int MEM_DEPTH_LOG2   = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_AXI_ID_WIDTH-1:0]     awid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]                    awlen,
  input  logic [2:0]                    awsize,
  input  logic [1:0]                    awburst,
  input  logic                          awlock,
  input  logic [3:0]                    awcache,
  input  logic [2:0]                    awprot,
  input  logic [3:0]                    awqos,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] wstrb,
  input  logic                          wlast,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [C_AXI_ID_WIDTH-1:0]     bid,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  input  logic [C_AXI_ID_WIDTH-1:0]     arid,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]                    arlen,
  input  logic [2:0]                    arsize,
  input  logic [1:0]                    arburst,
  input  logic                          arlock,
  input  logic [3:0]                    arcache,
  input  logic [2:0]                    arprot,
  input  logic [3:0]                    arqos,
  input  logic                          arvalid,
  output logic                          arready,
  output logic [C_AXI_ID_WIDTH-1:0]     rid,
  output logic [C_AXI_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                    rresp,
  output logic                          rlast,
  output logic                          rvalid,
  input  logic                          rready
);

  localparam int B  = $clog2(C_AXI_DATA_WIDTH/8);
  localparam int IW = MEM_DEPTH_LOG2;

  // Side-band qualifiers and out-of-range address bits are accepted but have no effect.
  logic unused_inputs;
  assign unused_inputs = ^{awsize, awlock, awcache, awprot, awqos, awaddr,
                           arsize, arlock, arcache, arprot, arqos, araddr};

  // ---------------- write engine ----------------
  wr_state_t                 w_state, w_next;
  logic [C_AXI_ID_WIDTH-1:0] w_id;
  logic [IW-1:0]             w_idx;
  logic [7:0]                w_len, w_cnt;
  logic                      w_fixed, w_unsup, w_err;
  logic                      aw_hs, w_hs, w_final;

  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign w_final = (w_cnt == w_len);

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    if (!rst) begin
      unique case (w_state)
        W_IDLE: begin
          awready = 1'b1;
          if (awvalid) w_next = W_DATA;
        end
        W_DATA: begin
          wready = 1'b1;
          if (wvalid && w_final) w_next = W_RESP;
        end
        W_RESP: begin
          bvalid = 1'b1;
          if (bready) w_next = W_IDLE;
        end
        default: w_next = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_fixed <= 1'b0;
      w_unsup <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        w_id    <= awid;
        w_idx   <= awaddr[B+IW-1:B];
        w_len   <= awlen;
        w_cnt   <= '0;
        w_fixed <= (awburst == BURST_FIXED);
        w_unsup <= !burst_supported(awburst);
        w_err   <= !burst_supported(awburst);
      end else if (w_hs) begin
        w_cnt <= w_cnt + 8'd1;
        if (!w_fixed) w_idx <= w_idx + 1'b1;
        // wlast must coincide exactly with the counted final beat.
        if (wlast != w_final) w_err <= 1'b1;
      end
    end
  end

  assign bid   = bvalid ? w_id : '0;
  assign bresp = (bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read engine ----------------
  rd_state_t                 r_state, r_next;
  logic [C_AXI_ID_WIDTH-1:0] r_id;
  logic [IW-1:0]             r_idx, ar_idx, mem_raddr;
  logic [7:0]                r_len, r_cnt;
  logic                      r_fixed, r_unsup;
  logic                      ar_hs, r_hs, r_final, mem_re;
  logic [C_AXI_DATA_WIDTH-1:0] mem_rdata;

  assign ar_idx  = araddr[B+IW-1:B];
  assign ar_hs   = arvalid && arready;
  assign r_hs    = rvalid && rready;
  assign r_final = (r_cnt == r_len);

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    if (!rst) begin
      unique case (r_state)
        R_IDLE: begin
          arready = 1'b1;
          if (arvalid) r_next = R_DATA;
        end
        R_DATA: begin
          rvalid = 1'b1;
          if (rready && r_final) r_next = R_IDLE;
        end
      endcase
    end
  end

  // r_idx always holds the index of the beat after the one being presented.
  assign mem_re    = ar_hs || (r_hs && !r_final);
  assign mem_raddr = ar_hs ? ar_idx : r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fixed <= 1'b0;
      r_unsup <= 1'b0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_id    <= arid;
        r_len   <= arlen;
        r_cnt   <= '0;
        r_fixed <= (arburst == BURST_FIXED);
        r_unsup <= !burst_supported(arburst);
        r_idx   <= (arburst == BURST_FIXED) ? ar_idx : ar_idx + 1'b1;
      end else if (r_hs && !r_final) begin
        r_cnt <= r_cnt + 8'd1;
        if (!r_fixed) r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign rid   = rvalid ? r_id : '0;
  assign rresp = (rvalid && r_unsup) ? RESP_SLVERR : RESP_OKAY;
  assign rlast = rvalid && r_final;
  assign rdata = (rvalid && !r_unsup) ? mem_rdata : '0;

  ddr3_axi_bram_mem #(
    .DATA_WIDTH (C_AXI_DATA_WIDTH),
    .DEPTH_LOG2 (MEM_DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (w_hs && !w_unsup),
    .waddr (w_idx),
    .wstrb (wstrb),
    .wdata (wdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_ddr3_axi_bram_responder.sv
//------------------------------------------------------------------------------
// tb_ddr3_axi_bram_responder: vector table of AXI bursts plus hand-written corner sequences. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ddr3_axi_bram_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [11:0]  awid, arid, bid, rid;
  logic [32:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [1:0]   awburst, arburst, bresp, rresp;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic [255:0] wdata, rdata;
  logic [31:0]  wstrb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ddr3_axi_bram_responder dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(3'd5), .awburst(awburst),
    .awlock(1'b0), .awcache(4'd0), .awprot(3'd0), .awqos(4'd0),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(3'd5), .arburst(arburst),
    .arlock(1'b0), .arcache(4'd0), .arprot(3'd0), .arqos(4'd0),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    bit           wr;
    logic [11:0]  id;
    logic [32:0]  addr;
    logic [7:0]   len;
    logic [1:0]   burst;
    logic [255:0] base;
    logic [255:0] step;
    logic [31:0]  strb;
    bit           bad_wlast;
    bit           stall;
    logic [1:0]   resp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit wr, logic [11:0] id, logic [32:0] addr, logic [7:0] len,
                              logic [1:0] burst, logic [255:0] base, logic [255:0] step,
                              logic [31:0] strb, bit bad_wlast, bit stall, logic [1:0] resp);
    vec_t v;
    v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.burst = burst;
    v.base = base; v.step = step; v.strb = strb; v.bad_wlast = bad_wlast;
    v.stall = stall; v.resp = resp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_write(input int idx, input vec_t v);
    int n;
    @(negedge clk);
    awid = v.id; awaddr = v.addr; awlen = v.len; awburst = v.burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("v%0d awready", idx), awready, 1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    for (int k = 0; k <= int'(v.len); k++) begin
      wdata  = v.base + v.step * 256'(k);
      wstrb  = v.strb;
      wlast  = v.bad_wlast ? (k == 0) : (k == int'(v.len));
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      chk($sformatf("v%0d wready beat %0d", idx, k), wready, 1);
      @(posedge clk);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("v%0d bvalid", idx), bvalid, 1);
    chk($sformatf("v%0d bresp", idx), bresp, v.resp);
    chk($sformatf("v%0d bid", idx), bid, v.id);
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input int idx, input vec_t v);
    int n, k, cyc;
    @(negedge clk);
    arid = v.id; araddr = v.addr; arlen = v.len; arburst = v.burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("v%0d arready", idx), arready, 1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    k = 0; cyc = 0;
    while (k <= int'(v.len) && cyc < 2000) begin
      rready = v.stall ? cyc[0] : 1'b1;
      chk($sformatf("v%0d rvalid c%0d", idx, cyc), rvalid, 1);
      if (rvalid) begin
        chk($sformatf("v%0d rdata beat %0d", idx, k), rdata, v.base + v.step * 256'(k));
        chk($sformatf("v%0d rid beat %0d", idx, k), rid, v.id);
        chk($sformatf("v%0d rresp beat %0d", idx, k), rresp, v.resp);
        chk($sformatf("v%0d rlast beat %0d", idx, k), rlast, (k == int'(v.len)));
        if (rready) k++;
      end
      cyc++;
      @(negedge clk);
    end
    rready = 1'b0;
    chk($sformatf("v%0d rvalid after last", idx), rvalid, 0);
    chk($sformatf("v%0d read cycles", idx), cyc, (v.stall ? 2 : 1) * (int'(v.len) + 1));
  endtask

  localparam logic [31:0]  ALL  = 32'hFFFF_FFFF;
  localparam logic [255:0] ONES = {256{1'b1}};

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

    //       wr id      addr        len   burst  base         step     strb bad st resp
    vecs.push_back(mk(1, 12'h005, 33'h40,   8'd3,  2'b01, 256'h11,   256'h11, ALL, 0, 0, 2'b00));
    vecs.push_back(mk(0, 12'h007, 33'h40,   8'd3,  2'b01, 256'h11,   256'h11, ALL, 0, 0, 2'b00));
    vecs.push_back(mk(1, 12'h001, 33'h100,  8'd0,  2'b01, 256'h0,    256'h0,  ALL, 0, 0, 2'b00));
    vecs.push_back(mk(1, 12'h002, 33'h100,  8'd0,  2'b01, ONES,      256'h0,  1,   0, 0, 2'b00));
    vecs.push_back(mk(0, 12'h003, 33'h100,  8'd0,  2'b01, 256'hFF,   256'h0,  ALL, 0, 0, 2'b00));
    vecs.push_back(mk(1, 12'h004, 33'h200,  8'd2,  2'b00, 256'hA,    256'h1,  ALL, 0, 0, 2'b00));
    vecs.push_back(mk(0, 12'h005, 33'h200,  8'd2,  2'b00, 256'hC,    256'h0,  ALL, 0, 0, 2'b00));
    vecs.push_back(mk(1, 12'h006, 33'h40,   8'd1,  2'b10, 256'h99,   256'h1,  ALL, 0, 0, 2'b10));
    vecs.push_back(mk(0, 12'h007, 33'h40,   8'd1,  2'b01, 256'h11,   256'h11, ALL, 0, 0, 2'b00));
    vecs.push_back(mk(1, 12'h008, 33'h300,  8'd1,  2'b01, 256'h5,    256'h1,  ALL, 1, 0, 2'b10));
    vecs.push_back(mk(0, 12'h009, 33'h40,   8'd1,  2'b11, 256'h0,    256'h0,  ALL, 0, 0, 2'b10));
    vecs.push_back(mk(0, 12'hABC, 33'h8040, 8'd0,  2'b01, 256'h11,   256'h0,  ALL, 0, 0, 2'b00));
    vecs.push_back(mk(1, 12'hFFF, 33'h7FE0, 8'd1,  2'b01, 256'h77,   256'h1,  ALL, 0, 0, 2'b00));
    vecs.push_back(mk(0, 12'h010, 33'h0,    8'd0,  2'b01, 256'h78,   256'h0,  ALL, 0, 0, 2'b00));
    vecs.push_back(mk(0, 12'h011, 33'h7FE0, 8'd1,  2'b01, 256'h77,   256'h1,  ALL, 0, 0, 2'b00));
    vecs.push_back(mk(1, 12'h012, 33'h1000, 8'd15, 2'b01, 256'h100,  256'h1,  ALL, 0, 0, 2'b00));
    vecs.push_back(mk(0, 12'h013, 33'h1000, 8'd15, 2'b01, 256'h100,  256'h1,  ALL, 0, 1, 2'b00));
    vecs.push_back(mk(1, 12'h014, 33'h2000, 8'd255,2'b01, 256'h1000, 256'h1,  ALL, 0, 0, 2'b00));
    vecs.push_back(mk(0, 12'h015, 33'h2000, 8'd255,2'b01, 256'h1000, 256'h1,  ALL, 0, 0, 2'b00));
    vecs.push_back(mk(0, 12'h016, 33'h2000, 8'd3,  2'b00, 256'h1000, 256'h0,  ALL, 0, 0, 2'b00));

    repeat (3) @(negedge clk);
    chk("rst awready", awready, 0); chk("rst wready", wready, 0);
    chk("rst bvalid", bvalid, 0);   chk("rst arready", arready, 0);
    chk("rst rvalid", rvalid, 0);   chk("rst rlast", rlast, 0);
    chk("rst bresp", bresp, 0);     chk("rst rresp", rresp, 0);
    chk("rst bid", bid, 0);         chk("rst rid", rid, 0);
    chk("rst rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst awready", awready, 1);
    chk("post-rst arready", arready, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) do_write(i, vecs[i]);
      else            do_read(i, vecs[i]);
    end

    // B channel backpressure: response must hold and AW must stay closed.
    @(negedge clk);
    awid = 12'h055; awaddr = 33'h400; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    chk("bp awready", awready, 1);
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b1; wdata = 256'h1234; wstrb = ALL; wlast = 1'b1; bready = 1'b0;
    @(posedge clk); @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp bvalid c%0d", c), bvalid, 1);
      chk($sformatf("bp awready c%0d", c), awready, 0);
      chk($sformatf("bp bid c%0d", c), bid, 12'h055);
      chk($sformatf("bp bresp c%0d", c), bresp, 2'b00);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bp bvalid done", bvalid, 0);
    chk("bp awready back", awready, 1);
    do_read(100, mk(0, 12'h056, 33'h400, 8'd0, 2'b01, 256'h1234, 256'h0, ALL, 0, 0, 2'b00));

    // Same-cycle write and read of index 8 (holds 0xFF): read sees the old word.
    @(negedge clk);
    awid = 12'h001; awaddr = 33'h100; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 256'hABCD; wstrb = ALL; wlast = 1'b1;
    arid = 12'h002; araddr = 33'h100; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1; rready = 1'b1;
    chk("coll wready", wready, 1);
    chk("coll arready", arready, 1);
    @(posedge clk); @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0; bready = 1'b1;
    chk("coll rvalid", rvalid, 1);
    chk("coll old rdata", rdata, 256'hFF);
    chk("coll rlast", rlast, 1);
    chk("coll bvalid", bvalid, 1);
    @(posedge clk); @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    chk("coll rvalid done", rvalid, 0);
    chk("coll bvalid done", bvalid, 0);
    do_read(101, mk(0, 12'h003, 33'h100, 8'd0, 2'b01, 256'hABCD, 256'h0, ALL, 0, 0, 2'b00));

    // Reset in the middle of a 16-beat read abandons it.
    @(negedge clk);
    arid = 12'h020; araddr = 33'h1000; arlen = 8'd15; arburst = 2'b01; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    chk("rstmid rvalid before", rvalid, 1);
    chk("rstmid rdata beat1", rdata, 256'h101);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid rvalid", rvalid, 0);
    chk("rstmid arready", arready, 0);
    chk("rstmid rdata", rdata, 0);
    rst = 1'b0; rready = 1'b0;
    @(negedge clk);
    chk("rstmid arready after", arready, 1);
    chk("rstmid rvalid after", rvalid, 0);
    do_read(102, mk(0, 12'h021, 33'h1000, 8'd1, 2'b01, 256'h100, 256'h1, ALL, 0, 0, 2'b00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/ddr3_axi_bram_responder.md
Name: ddr3_axi_bram_responder

Overview:
AXI4 slave responder that terminates the master side of the DDR3 user AXI interface with an on-chip byte-enabled block RAM.
Used as a DDR3 stand-in for bring-up and simulation, so user cores can run without the MIG.
Independent write and read engines, each with one outstanding burst; single clock domain.

Parameters:
C_AXI_ID_WIDTH, 12, AXI ID width
C_AXI_ADDR_WIDTH, 33, byte address width
C_AXI_DATA_WIDTH, 256, data width (power of 2, ≥32)
MEM_DEPTH_LOG2, 10, log2 of RAM depth in data-width words

Ports:
clk  input  1  interface clock
rst  input  1  synchronous active-high reset
awid/awaddr/awlen/awburst  input  ID/ADDR/8/2  write address
awsize/awlock/awcache/awprot/awqos  input  3/1/4/3/4  accepted, ignored
awvalid  input  1; awready  output  1
wdata/wstrb/wlast/wvalid  input  DATA/DATA/8/1/1; wready  output  1
bid/bresp/bvalid  output  ID/2/1; bready  input  1
arid/araddr/arlen/arburst  input  ID/ADDR/8/2  read address
arsize/arlock/arcache/arprot/arqos  input  3/1/4/3/4  accepted, ignored
arvalid  input  1; arready  output  1
rid/rdata/rresp/rlast/rvalid  output  ID/DATA/2/1/1; rready  input  1

Behaviour:
- Interface decision: one clock `clk`. `rst` is synchronous and active-high. While `rst` is high, all outputs are 0: awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata.
- RAM contents are not reset.
- Word index: addr[B+MEM_DEPTH_LOG2-1:B], where B = log2(DATA/8).
  - Upper address bits are ignored (aliasing).
  - Index wraps modulo depth.
  - Each beat advances by one full data word, regardless of size.
- Burst types:
  - FIXED (00): index held for all beats.
  - INCR (01): index +1 per beat.
  - WRAP (10) or 11: unsupported. The burst completes with SLVERR, no RAM writes occur, and rdata is 0.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: awready=1. On awvalid&awready, latch id/index/len/burst; go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes wdata under wstrb (per-byte enable). Beat counter runs 0..awlen; after beat awlen, go to W_RESP.
  - wlast is checked, not used for counting. wlast high on a non-final beat, or low on the final beat, sets a sticky SLVERR for that burst.
  - W_RESP: bvalid=1, bid=latched id, bresp=OKAY(00) or SLVERR(10). Held stable until bready. Then go to W_IDLE, so awready returns the next cycle.
  - Minimum write burst: 1 AW cycle + (len+1) W cycles + 1 B cycle.
- Read FSM (R_IDLE, R_DATA):
  - R_IDLE: arready=1. On handshake at cycle N, latch id/len/burst and issue a RAM read of the start index. rvalid=1 at N+1 with beat 0.
  - R_DATA: on rvalid&rready of a non-final beat, the next index is read the same cycle and presented at the next cycle. This gives one beat per cycle under constant rready.
  - rdata/rid/rresp/rlast are held stable while rvalid&!rready.
  - rlast=1 only on beat arlen. After the final handshake, rvalid=0 and the FSM goes to R_IDLE.
- Read and write engines run concurrently. If a read and a write hit the same index in the same cycle, the read returns the old data (read-first). The write is visible to reads issued from the next cycle on.
- awlen=0/arlen=0 gives single-beat bursts. arlen=255 gives 256 beats; the counter must be 8 bits wide, plus a terminal compare.
- rst asserted mid-burst abandons the burst without a response. Partially written beats remain in RAM.

Decomposition:
- Package ddr3_axi_pkg:
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - burst constants BURST_FIXED/INCR/WRAP;
  - enums for the write FSM (W_IDLE, W_DATA, W_RESP) and read FSM (R_IDLE, R_DATA).
- One sub-module: ddr3_axi_bram_mem. It is a simple dual-port RAM with one write port (per-byte enable) and one registered read port with read-first behaviour, parameterised on data width and depth.

Test Plan:
- INCR write, awaddr=0x40, awlen=3, 4 beats of wdata 0x11..0x44, all wstrb ones → bvalid with bresp=00 and bid echoed. INCR read of the same address, arlen=3 → beats 0x11,0x22,0x33,0x44 on consecutive cycles; rlast only on beat 3.
- Partial strobe: write 0xFFFF.. with wstrb=1 (byte 0 only) over a word preloaded to 0 → readback is 0x..00FF.
- FIXED write, len=2, data A,B,C → single word holds C. FIXED read, len=2 → C,C,C.
- Protocol errors:
  - awburst=WRAP → bresp=10, RAM unchanged.
  - INCR write len=1 with wlast on beat 0 → bresp=10.
  - arburst=11, len=1 → two beats rdata=0, rresp=10.
- Backpressure:
  - rready toggled every other cycle during a 16-beat read → data stable while stalled, no beats dropped or duplicated.
  - bready held low for 5 cycles → bvalid held, awready stays 0.
- Concurrency and reset:
  - Simultaneous write and read on the same index → read returns the old value; a later read returns the new value.
  - rst pulsed mid-read → rvalid=0 next cycle, arready=1 the cycle after rst falls.
  - Depth wrap: INCR from the last index → second beat lands at index 0.
